// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, a one-entry
// instruction buffer for ID, and redirect/flush that kills stale responses.
module inst_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_rst,
  input  logic                  if_en,
  output logic                  if_valid,
  output logic [31:0]           inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  redirect_en,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [31:0]           imem_rdata,
  output logic                  fetch_busy
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] pc, pc_n;
  logic [ADDR_WIDTH-1:0] inst_pc_n;
  logic [31:0]           inst_n;
  logic                  if_valid_n;
  logic                  kill, kill_n;
  logic                  consume, buf_free, flush;
  logic [ADDR_WIDTH-1:0] flush_pc;

  assign consume    = if_en & if_valid;
  assign buf_free   = ~if_valid | consume;
  assign flush      = if_rst | redirect_en;
  assign flush_pc   = if_rst ? (PC_RESET & ALIGN_MASK) : (redirect_pc & ALIGN_MASK);
  assign imem_req   = (state == S_IDLE) & buf_free & ~flush & rst;
  assign imem_addr  = pc;
  assign fetch_busy = (state == S_WAIT) & rst;

  // A flush never abandons an in-flight handshake: it marks the response
  // as killed so the data is dropped when rvalid finally arrives.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    kill_n     = kill;
    if_valid_n = if_valid;
    inst_n     = inst;
    inst_pc_n  = inst_pc;
    if (flush) begin
      pc_n       = flush_pc;
      if_valid_n = 1'b0;
      if (state == S_WAIT) begin
        if (imem_rvalid) begin
          state_n = S_IDLE;
          kill_n  = 1'b0;
        end else begin
          kill_n  = 1'b1;
        end
      end
    end else begin
      if (consume) begin
        if_valid_n = 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (imem_req && imem_gnt) begin
            state_n = S_WAIT;
            kill_n  = 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_n = S_IDLE;
            kill_n  = 1'b0;
            if (!kill) begin
              inst_n     = imem_rdata;
              inst_pc_n  = pc;
              if_valid_n = 1'b1;
              pc_n       = pc + ADDR_WIDTH'(4);
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      pc       <= PC_RESET & ALIGN_MASK;
      kill     <= 1'b0;
      if_valid <= 1'b0;
      inst     <= '0;
      inst_pc  <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      kill     <= kill_n;
      if_valid <= if_valid_n;
      inst     <= inst_n;
      inst_pc  <= inst_pc_n;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: transaction-level fetch model plus a responding
// instruction memory with configurable grant and response delays.
module tb_inst_fetch_unit;

  localparam logic [31:0] PC_RESET = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_rst = 1'b0;
  logic        if_en = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        fetch_busy;

  inst_fetch_unit #(.ADDR_WIDTH(32), .PC_RESET(PC_RESET)) dut (
    .clk(clk),
    .rst(rst),
    .if_rst(if_rst),
    .if_en(if_en),
    .if_valid(if_valid),
    .inst(inst),
    .inst_pc(inst_pc),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  // Model: an outstanding-request queue (at most one entry) and the buffer.
  typedef struct {
    logic [31:0] addr;
    bit          killed;
  } txn_t;

  txn_t        out_q[$];
  logic [31:0] m_pc = '0;
  logic [31:0] m_inst = '0;
  logic [31:0] m_inst_pc = '0;
  bit          m_valid = 1'b0;
  bit          m_known = 1'b0;
  bit          m_req = 1'b0;

  logic [31:0] mem_addr[$];
  int          mem_lat[$];
  bit          from_mem = 1'b0;
  int          g_wait = 0;

  logic [31:0] acc_addr[$];
  logic [31:0] dlv_pc[$];
  logic [31:0] dlv_inst[$];
  int          dlv_cyc[$];

  bit          d_rst = 1'b0;
  bit          d_if_rst = 1'b0;
  bit          d_redirect_en = 1'b0;
  bit          d_if_en = 1'b1;
  logic [31:0] d_redirect_pc = '0;
  bit          k_rand = 1'b0;
  int          k_gmin = 0;
  int          k_gmax = 0;
  int          k_lmin = 0;
  int          k_lmax = 0;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a | 32'hA000_0000;
  endfunction

  function automatic bit model_req();
    return m_known && rst && !if_rst && !redirect_en && out_q.size() == 0 && (!m_valid || if_en);
  endfunction

  function automatic void modelStep();
    txn_t t;
    if (!rst) begin
      m_known   = 1'b1;
      m_pc      = PC_RESET;
      m_valid   = 1'b0;
      m_inst    = '0;
      m_inst_pc = '0;
      out_q.delete();
    end else if (m_known) begin
      if (if_rst || redirect_en) begin
        m_pc    = if_rst ? PC_RESET : (redirect_pc & 32'hFFFF_FFFC);
        m_valid = 1'b0;
        if (out_q.size() != 0) begin
          if (imem_rvalid) begin
            out_q.delete();
          end else begin
            t = out_q[0];
            t.killed = 1'b1;
            out_q[0] = t;
          end
        end
      end else begin
        if (m_valid && if_en) m_valid = 1'b0;
        if (out_q.size() == 0) begin
          if (m_req && imem_gnt) begin
            t.addr   = m_pc;
            t.killed = 1'b0;
            out_q.push_back(t);
            acc_addr.push_back(m_pc);
          end
        end else if (imem_rvalid) begin
          t = out_q.pop_front();
          if (!t.killed) begin
            m_valid   = 1'b1;
            m_inst    = mem_data(t.addr);
            m_inst_pc = t.addr;
            m_pc      = t.addr + 32'd4;
            dlv_pc.push_back(t.addr);
            dlv_inst.push_back(m_inst);
            dlv_cyc.push_back(cyc);
          end
        end
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkOutput();
    if (!m_known) return;
    check("if_valid", 32'(if_valid), 32'(m_valid));
    check("inst", inst, m_inst);
    check("inst_pc", inst_pc, m_inst_pc);
    check("imem_req", 32'(imem_req), 32'(m_req));
    check("imem_addr", imem_addr, m_pc);
    check("fetch_busy", 32'(fetch_busy), 32'(rst && out_q.size() != 0));
  endtask

  // One clock: drive at negedge, compare just after, update model at posedge.
  task automatic applyStimulus();
    @(negedge clk);
    if (k_rand) begin
      d_rst         = ($urandom_range(0, 199) != 0);
      d_if_rst      = ($urandom_range(0, 59) == 0);
      d_redirect_en = ($urandom_range(0, 14) == 0);
      d_redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
      d_if_en       = ($urandom_range(0, 3) != 0);
    end
    rst         = d_rst;
    if_rst      = d_if_rst;
    redirect_en = d_redirect_en;
    redirect_pc = d_redirect_pc;
    if_en       = d_if_en;
    from_mem = (mem_addr.size() != 0 && mem_lat[0] == 0);
    if (from_mem) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data(mem_addr[0]);
    end else if (k_rand && out_q.size() == 0 && $urandom_range(0, 9) == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    m_req = model_req();
    if (m_req && mem_addr.size() == 0) begin
      if (g_wait == 0) begin
        imem_gnt = 1'b1;
      end else begin
        imem_gnt = 1'b0;
        g_wait--;
      end
    end else begin
      imem_gnt = k_rand && !m_req && ($urandom_range(0, 9) == 0);
    end
    #1;
    checkOutput();
    @(posedge clk);
    if (from_mem) begin
      void'(mem_addr.pop_front());
      void'(mem_lat.pop_front());
    end else if (mem_addr.size() != 0 && mem_lat[0] > 0) begin
      mem_lat[0] = mem_lat[0] - 1;
    end
    if (m_req && imem_gnt) begin
      mem_addr.push_back(m_pc);
      mem_lat.push_back($urandom_range(k_lmin, k_lmax));
      g_wait = $urandom_range(k_gmin, k_gmax);
    end
    modelStep();
    cyc++;
  endtask

  task automatic clearLogs();
    acc_addr.delete();
    dlv_pc.delete();
    dlv_inst.delete();
    dlv_cyc.delete();
  endtask

  task automatic doReset();
    d_rst = 1'b0;
    repeat (2) applyStimulus();
    d_rst = 1'b1;
    clearLogs();
  endtask

  task automatic waitAcc(input int n, input string what);
    int k = 0;
    while (acc_addr.size() < n && k < 60) begin
      applyStimulus();
      k++;
    end
    check(what, 32'(acc_addr.size() >= n), 32'd1);
  endtask

  task automatic waitDlv(input int n, input string what);
    int k = 0;
    while (dlv_pc.size() < n && k < 60) begin
      applyStimulus();
      k++;
    end
    check(what, 32'(dlv_pc.size() >= n), 32'd1);
  endtask

  initial begin
    // Streaming with a zero-wait memory: one instruction every 2 cycles.
    doReset();
    repeat (6) applyStimulus();
    check("strm_acc_n", 32'(acc_addr.size()), 32'd3);
    check("strm_dlv_n", 32'(dlv_pc.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < acc_addr.size()) check("strm_addr", acc_addr[i], 32'(4 * i));
      if (i < dlv_pc.size()) begin
        check("strm_pc", dlv_pc[i], 32'(4 * i));
        check("strm_inst", dlv_inst[i], 32'hA000_0000 + 32'(4 * i));
      end
      if (i > 0 && i < dlv_cyc.size()) check("strm_gap", 32'(dlv_cyc[i] - dlv_cyc[i-1]), 32'd2);
    end

    // Backpressure: buffer held while ID stalls.
    d_if_en = 1'b0;
    doReset();
    waitDlv(1, "bp_first");
    repeat (4) applyStimulus();
    #1;
    check("bp_valid", 32'(if_valid), 32'd1);
    check("bp_inst_pc", inst_pc, 32'h0);
    check("bp_inst", inst, 32'hA000_0000);
    check("bp_req", 32'(imem_req), 32'd0);
    d_if_en = 1'b1;
    waitAcc(2, "bp_resume");
    if (acc_addr.size() >= 2) check("bp_addr", acc_addr[1], 32'h4);

    // Redirect while the request for 8 is in flight.
    k_lmin = 2;
    k_lmax = 2;
    doReset();
    waitAcc(3, "rd_wait");
    d_redirect_en = 1'b1;
    d_redirect_pc = 32'h0000_0103;
    applyStimulus();
    d_redirect_en = 1'b0;
    waitAcc(4, "rd_next");
    if (acc_addr.size() >= 4) check("rd_addr", acc_addr[3], 32'h100);
    check("rd_dlv_n", 32'(dlv_pc.size()), 32'd2);
    #1;
    check("rd_valid", 32'(if_valid), 32'd0);

    // Redirect in the same cycle as the response for 4.
    k_lmin = 0;
    k_lmax = 0;
    doReset();
    waitAcc(2, "rc_wait");
    d_redirect_en = 1'b1;
    d_redirect_pc = 32'h0000_0040;
    applyStimulus();
    d_redirect_en = 1'b0;
    waitAcc(3, "rc_next");
    if (acc_addr.size() >= 3) check("rc_addr", acc_addr[2], 32'h40);
    check("rc_dlv_n", 32'(dlv_pc.size()), 32'd1);

    // Flush against a slow memory while waiting on addr 4.
    k_gmin = 3;
    k_gmax = 3;
    k_lmin = 3;
    k_lmax = 3;
    doReset();
    g_wait = 3;
    waitAcc(2, "fl_wait");
    applyStimulus();
    d_if_rst = 1'b1;
    applyStimulus();
    d_if_rst = 1'b0;
    begin
      int k = 0;
      while (mem_addr.size() != 0 && k < 20) begin
        applyStimulus();
        k++;
      end
    end
    check("fl_drain", 32'(mem_addr.size()), 32'd0);
    #1;
    check("fl_busy", 32'(fetch_busy), 32'd0);
    check("fl_req", 32'(imem_req), 32'd1);
    check("fl_imem_addr", imem_addr, PC_RESET);
    waitAcc(3, "fl_next");
    if (acc_addr.size() >= 3) check("fl_addr", acc_addr[2], PC_RESET);
    check("fl_dlv_n", 32'(dlv_pc.size()), 32'd1);

    // Reset while waiting on addr 4; the late response must be ignored.
    k_gmin = 0;
    k_gmax = 0;
    doReset();
    g_wait = 0;
    waitAcc(2, "rs_wait");
    d_rst = 1'b0;
    applyStimulus();
    #1;
    check("rs_valid", 32'(if_valid), 32'd0);
    check("rs_inst", inst, 32'h0);
    check("rs_req", 32'(imem_req), 32'd0);
    check("rs_busy", 32'(fetch_busy), 32'd0);
    check("rs_imem_addr", imem_addr, PC_RESET);
    d_rst = 1'b1;
    waitAcc(3, "rs_next");
    if (acc_addr.size() >= 3) check("rs_addr", acc_addr[2], PC_RESET);
    check("rs_dlv_n", 32'(dlv_pc.size()), 32'd1);

    // Randomized traffic against the model.
    k_gmin = 0;
    k_gmax = 3;
    k_lmin = 0;
    k_lmax = 3;
    doReset();
    k_rand = 1'b1;
    repeat (3000) applyStimulus();
    k_rand = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
